// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared types and helpers for the pipelined
// approximate multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_OR    = 2'b01,
    MODE_CARRY = 2'b10,
    MODE_ELIM  = 2'b11
  } mode_e;

  localparam int DEF_WIDTH = 8;

  function automatic int pairs_f(input int w);
    return w / 2;
  endfunction

  function automatic int t_width_f(input int w);
    return w + 1;
  endfunction

  function automatic int b_width_f(input int w);
    return w - 1;
  endfunction

  // Returns {carry, sum} for one approximate half-adder cell.
  function automatic logic [1:0] ha_cell(
    input mode_e mode,
    input logic  a,
    input logic  b
  );
    logic [1:0] cs;
    cs = 2'b00;
    unique case (mode)
      MODE_EXACT: cs = {a & b, a ^ b};
      MODE_OR:    cs = {1'b0, a | b};
      MODE_CARRY: cs = {a, 1'b0};
      MODE_ELIM:  cs = 2'b00;
      default:    cs = 2'b00;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/approx_mul_pipe_ha_row.sv
// approx_ha_row: combinational compressor for one pair of
// partial-product rows with per-column approximation.
module approx_ha_row
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]       a_row_i,
  input  logic [WIDTH-1:0]       b_row_i,
  input  logic [2*(WIDTH-1)-1:0] mode_i,
  output logic [WIDTH:0]         t_o,
  output logic [WIDTH-2:0]       b_o
);

  logic [1:0] cs;

  always_comb begin
    t_o = '0;
    b_o = '0;
    cs  = '0;
    t_o[0] = a_row_i[0];
    b_o[WIDTH-2] = b_row_i[WIDTH-1];
    for (int j = 0; j < WIDTH-1; j++) begin
      cs = ha_cell(mode_e'(mode_i[2*j +: 2]),
                   a_row_i[j+1], b_row_i[j]);
      t_o[j+1] = cs[0];
      // Top column carries into t; b's top bit is the b-row MSB.
      if (j == WIDTH-2) t_o[WIDTH] = cs[1];
      else              b_o[j]     = cs[1];
    end
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: two-stage approximate unsigned multiplier
// behind a valid/ready stream.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  input  logic [2*(WIDTH-1)-1:0] in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_p,
  output logic                   out_ovf,
  output logic                   out_exact
);

  localparam int PAIRS = pairs_f(WIDTH);
  localparam int TW    = t_width_f(WIDTH);
  localparam int BW    = b_width_f(WIDTH);
  localparam int SW    = 2*WIDTH + 1;

  logic s1_valid_q, s2_valid_q;
  logic s1_load, s2_load, accept;

  logic [TW-1:0] t_d [PAIRS];
  logic [TW-1:0] t_q [PAIRS];
  logic [BW-1:0] b_d [PAIRS];
  logic [BW-1:0] b_q [PAIRS];
  logic          exact_q;

  logic [SW-1:0]      sum_d;
  logic [2*WIDTH-1:0] p_q;
  logic               ovf_q;
  logic               ex_q;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && s1_load;

  for (genvar k = 0; k < PAIRS; k++) begin : g_pair
    approx_ha_row #(.WIDTH(WIDTH)) u_row (
      .a_row_i (in_y & {WIDTH{in_x[2*k]}}),
      .b_row_i (in_y & {WIDTH{in_x[2*k+1]}}),
      .mode_i  (in_mode),
      .t_o     (t_d[k]),
      .b_o     (b_d[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PAIRS; k++) begin
        t_q[k] <= '0;
        b_q[k] <= '0;
      end
      exact_q <= 1'b0;
    end else if (accept) begin
      t_q     <= t_d;
      b_q     <= b_d;
      exact_q <= (in_mode == '0);
    end
  end

  // Each pair contributes t + 4*b, weighted by 4^k.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < PAIRS; k++) begin
      sum_d = sum_d
            + ((SW'(t_q[k]) + (SW'(b_q[k]) << 2)) << (2*k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      ex_q  <= 1'b0;
    end else if (s2_load && s1_valid_q) begin
      p_q   <= sum_d[2*WIDTH-1:0];
      ovf_q <= sum_d[2*WIDTH];
      ex_q  <= exact_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_p     = p_q;
  assign out_ovf   = ovf_q;
  assign out_exact = ex_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: table vectors, handshake corner cases and
// randomized stream against a weight-sum reference model.
module tb_approx_mul_pipe;

  localparam int W  = 8;
  localparam int MW = 2*(W-1);
  localparam int NT = 7;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [MW-1:0] in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] out_p;
  logic          out_ovf;
  logic          out_exact;

  int vec = 0;
  int bad = 0;

  typedef struct {
    logic [2*W:0] s;
    logic         ex;
  } exp_t;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [MW-1:0]  m;
    logic [2*W-1:0] p;
    logic           ovf;
    logic           ex;
  } vec_t;

  exp_t q[$];
  vec_t tbl [NT];
  exp_t bb  [NB];

  approx_mul_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf),
    .out_exact (out_exact)
  );

  always #5 clk = ~clk;

  // Sum of cell outputs at their bit weights, pair by pair.
  function automatic exp_t model(
    input logic [W-1:0]  x,
    input logic [W-1:0]  y,
    input logic [MW-1:0] m
  );
    exp_t   e;
    longint s;
    longint v;
    int     a, b, sm, cy;
    s = 0;
    for (int k = 0; k < W/2; k++) begin
      v = longint'(x[2*k] & y[0]);
      for (int j = 0; j < W-1; j++) begin
        a = int'(x[2*k] & y[j+1]);
        b = int'(x[2*k+1] & y[j]);
        case (m[2*j +: 2])
          2'b00:   begin sm = a ^ b; cy = a & b; end
          2'b01:   begin sm = a | b; cy = 0;     end
          2'b10:   begin sm = 0;     cy = a;     end
          default: begin sm = 0;     cy = 0;     end
        endcase
        v = v + (longint'(sm) << (j+1)) + (longint'(cy) << (j+2));
      end
      v = v + (longint'(x[2*k+1] & y[W-1]) << W);
      s = s + (v << (2*k));
    end
    e.s  = s[2*W:0];
    e.ex = (m == '0);
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    vec++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, act, req);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mon();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL dup: got product %0d, none expected", out_p);
      end else begin
        e = q.pop_front();
        chk("sb_p", 64'(out_p), 64'(e.s[2*W-1:0]));
        chk("sb_ovf", 64'(out_ovf), 64'(e.s[2*W]));
        chk("sb_exact", 64'(out_exact), 64'(e.ex));
      end
    end
    if (in_valid && in_ready)
      q.push_back(model(in_x, in_y, in_mode));
  endtask

  task automatic drive_rand();
    in_x    = W'($urandom);
    in_y    = W'($urandom);
    in_mode = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      settle(); mon(); adv();
    end
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int   got;
    int   acc;
    logic took, stall_prev;
    logic [2*W-1:0] prev_p;

    tbl[0] = '{8'd255, 8'd255, 14'h0000, 16'd65025, 1'b0, 1'b1};
    tbl[1] = '{8'd0,   8'd200, 14'h0000, 16'd0,     1'b0, 1'b1};
    tbl[2] = '{8'd3,   8'd3,   14'h0000, 16'd9,     1'b0, 1'b1};
    tbl[3] = '{8'd3,   8'd3,   14'h1555, 16'd7,     1'b0, 1'b0};
    tbl[4] = '{8'd3,   8'd3,   14'h2AAA, 16'd5,     1'b0, 1'b0};
    tbl[5] = '{8'd3,   8'd3,   14'h3FFF, 16'd1,     1'b0, 1'b0};
    tbl[6] = '{8'd13,  8'd11,  14'h0000, 16'd143,   1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(out_p), 64'd0);
    rst_n = 1'b1;
    settle();
    chk("rst_ready", 64'(in_ready), 64'd1);
    adv();

    for (int i = 0; i < NT; i++) begin
      in_x = tbl[i].x; in_y = tbl[i].y; in_mode = tbl[i].m;
      in_valid = 1'b1; out_ready = 1'b1;
      settle();
      chk("tbl_ready", 64'(in_ready), 64'd1);
      adv();
      in_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        settle();
        if (out_valid) begin
          got = 1;
          chk("tbl_lat", 64'(c), 64'd1);
          chk("tbl_p", 64'(out_p), 64'(tbl[i].p));
          chk("tbl_ovf", 64'(out_ovf), 64'(tbl[i].ovf));
          chk("tbl_exact", 64'(out_exact), 64'(tbl[i].ex));
        end
        adv();
      end
      if (got == 0) begin
        vec++; bad++;
        $display("FAIL tbl_timeout: vector %0d never valid", i);
      end
    end

    // Back-to-back stream with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NB + 2; i++) begin
      if (i < NB) begin
        drive_rand();
        in_valid = 1'b1;
        bb[i] = model(in_x, in_y, in_mode);
      end else begin
        in_valid = 1'b0;
      end
      settle();
      if (i < NB) chk("b2b_ready", 64'(in_ready), 64'd1);
      chk("b2b_valid", 64'(out_valid), 64'(i >= 2));
      if (i >= 2)
        chk("b2b_p", 64'(out_p), 64'(bb[i-2].s[2*W-1:0]));
      adv();
    end

    // Three pushes into a stalled sink.
    out_ready = 1'b0;
    drive_rand(); in_valid = 1'b1;
    settle(); chk("stall_rdy0", 64'(in_ready), 64'd1); mon(); adv();
    drive_rand();
    settle(); chk("stall_rdy1", 64'(in_ready), 64'd1); mon(); adv();
    drive_rand();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("stall_rdy_lo", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_p", 64'(out_p), 64'(q[0].s[2*W-1:0]));
      mon(); adv();
    end
    out_ready = 1'b1;
    settle();
    chk("stall_rel_rdy", 64'(in_ready), 64'd1);
    mon(); adv();
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    drive_rand(); in_valid = 1'b1;
    settle(); mon(); adv();
    drive_rand();
    settle(); mon(); adv();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_p", 64'(out_p), 64'd0);
    chk("mid_rst_exact", 64'(out_exact), 64'd0);
    q.delete();
    adv();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_rand(); in_valid = 1'b1;
    settle();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_v0", 64'(out_valid), 64'd0);
    mon(); adv();
    in_valid = 1'b0;
    settle(); chk("post_rst_v1", 64'(out_valid), 64'd0); mon(); adv();
    settle(); chk("post_rst_v2", 64'(out_valid), 64'd1); mon(); adv();
    drain();

    // Random stream with a randomly stalling sink.
    acc = 0; took = 1'b0; stall_prev = 1'b0; prev_p = '0;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        drive_rand();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      settle();
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_p", 64'(out_p), 64'(prev_p));
      end
      took = in_valid && in_ready;
      if (took) acc++;
      stall_prev = out_valid && !out_ready;
      prev_p = out_p;
      mon(); adv();
    end
    if (acc < 10000) begin
      vec++; bad++;
      $display("FAIL rand_timeout: accepted %0d, need 10000", acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
